mix_col_enc_seq: RTL and testbench

- Forward AES-128 MixColumns engine for the encrypt datapath; the counterpart of the decrypt-side inverse MixColumns.
- Iterative, not fully parallel. It accepts a 128-bit state through a valid/ready handshake and transforms COLS_PER_CYCLE columns per clock.
- It holds the result until downstream accepts it.
- It sits between ShiftRows and AddRoundKey in the encrypt round loop. A per-transaction Bypass input covers the final round, which skips MixColumns.

---
 rtl/mix_col_enc_seq_if.sv | 20 ++
 rtl/mix_col_enc_seq.sv | 115 +++++++++++
 tb/tb_mix_col_enc_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mix_col_enc_seq_if.sv
// Handshake bundle for the forward MixColumns engine: input state channel plus result channel.
interface mix_col_enc_seq_if;
  logic         InValid;
  logic         InReady;
  logic [127:0] DataIn;
  logic         Bypass;
  logic         OutValid;
  logic         OutReady;
  logic [127:0] DataOut;

  modport slave (
    input  InValid, DataIn, Bypass, OutReady,
    output InReady, OutValid, DataOut
  );

  modport master (
    output InValid, DataIn, Bypass, OutReady,
    input  InReady, OutValid, DataOut
  );
endinterface

// File: rtl/mix_col_enc_seq.sv
// Iterative AES-128 forward MixColumns, COLS_PER_CYCLE columns per clock, result held until taken.
// state | meaning:  IDLE = ready for a state | BUSY = columns in flight | DONE = result offered
module mix_col_enc_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic              Clk,
  input logic              Rst,
  mix_col_enc_seq_if.slave bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_col_enc_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [2:0] STEP     = 3'(COLS_PER_CYCLE);
  localparam logic [2:0] NUM_COLS = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_col;
  logic        r_bypass;
  logic [31:0] r_src [4];
  logic [31:0] r_res [4];

  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_accept;
  logic [2:0]  w_col_nxt;
  logic [1:0]  w_idx     [COLS_PER_CYCLE];
  logic [31:0] w_col_out [COLS_PER_CYCLE];

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    x0 = xtime(a0);
    x1 = xtime(a1);
    x2 = xtime(a2);
    x3 = xtime(a3);
    return {x0 ^ x1 ^ a1 ^ a2 ^ a3,
            a0 ^ x1 ^ x2 ^ a2 ^ a3,
            a0 ^ a1 ^ x2 ^ x3 ^ a3,
            x0 ^ a0 ^ a1 ^ a2 ^ x3};
  endfunction

  // One transform lane per column handled this cycle; lanes pick consecutive columns from r_col.
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
    assign w_idx[k]     = r_col[1:0] + 2'(k);
    assign w_col_out[k] = r_bypass ? r_src[w_idx[k]] : mix_col(r_src[w_idx[k]]);
  end

  assign w_col_nxt = r_col + STEP;
  assign w_accept  = bus.InValid & w_in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.InValid) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (w_col_nxt == NUM_COLS) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.OutReady;
        if (bus.OutReady) w_state_nxt = bus.InValid ? S_BUSY : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= S_IDLE;
      r_col    <= '0;
      r_bypass <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        r_src[c] <= '0;
        r_res[c] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_col    <= '0;
        r_bypass <= bus.Bypass;
        for (int c = 0; c < 4; c++) r_src[c] <= bus.DataIn[127 - 32*c -: 32];
      end else if (r_state == S_BUSY) begin
        r_col <= w_col_nxt;
        for (int k = 0; k < COLS_PER_CYCLE; k++) r_res[w_idx[k]] <= w_col_out[k];
      end
    end
  end

  assign bus.InReady  = w_in_ready;
  assign bus.OutValid = w_out_valid;
  assign bus.DataOut  = {r_res[0], r_res[1], r_res[2], r_res[3]};

endmodule

// File: tb/tb_mix_col_enc_seq.sv
// Directed bench for mix_col_enc_seq with three instances (1, 2 and 4 columns per cycle).
module tb_mix_col_enc_seq;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  logic         in_valid  [3];
  logic [127:0] data_in   [3];
  logic         bypass    [3];
  logic         out_ready [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic [127:0] data_out  [3];

  logic [127:0] exp_q [3][$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accept_cyc [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_col_enc_seq_if bus ();
    assign bus.InValid  = in_valid[g];
    assign bus.DataIn   = data_in[g];
    assign bus.Bypass   = bypass[g];
    assign bus.OutReady = out_ready[g];
    assign in_ready[g]  = bus.InReady;
    assign out_valid[g] = bus.OutValid;
    assign data_out[g]  = bus.DataOut;
    mix_col_enc_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic byp);
    logic [127:0] r;
    logic [7:0]   a [4];
    if (byp) return s;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127 - 32*c - 8*i -: 8];
      for (int i = 0; i < 4; i++)
        r[127 - 32*c - 8*i -: 8] = gmul(a[i], 8'h02) ^ gmul(a[(i+1)%4], 8'h03)
                                   ^ a[(i+2)%4] ^ a[(i+3)%4];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input int inst, input logic [127:0] d, input logic byp, input logic [127:0] exp);
    int n;
    n = 0;
    data_in[inst]  = d;
    bypass[inst]   = byp;
    in_valid[inst] = 1'b1;
    while (!in_ready[inst] && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("accept_timeout", {127'b0, in_ready[inst]}, 128'd1);
    tick();
    in_valid[inst]   = 1'b0;
    accept_cyc[inst] = cyc;
    exp_q[inst].push_back(exp);
  endtask

  task automatic wait_valid(input int inst, input logic scramble);
    int n;
    n = 0;
    while (!out_valid[inst] && n < 40) begin
      if (scramble) begin
        data_in[inst] = rand128();
        bypass[inst]  = 1'($urandom());
      end
      tick();
      n++;
    end
    check($sformatf("latency_i%0d", inst), 128'(cyc - accept_cyc[inst]), 128'(4 >> inst));
  endtask

  task automatic take(input int inst, input string tag);
    logic [127:0] exp;
    exp = (exp_q[inst].size() > 0) ? exp_q[inst].pop_front() : 'x;
    check(tag, data_out[inst], exp);
    out_ready[inst] = 1'b1;
    tick();
    out_ready[inst] = 1'b0;
    check({tag, "_drop"}, {127'b0, out_valid[inst]}, 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [127:0] a, b, c, d;

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      data_in[i]   = '0;
      bypass[i]    = 1'b0;
      out_ready[i] = 1'b0;
    end
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    tick();
    check("rst_inready",  {127'b0, in_ready[0]},  128'd1);
    check("rst_outvalid", {127'b0, out_valid[0]}, 128'd0);
    check("rst_dataout",  data_out[0],            128'd0);

    // FIPS-197 round 1 column mix
    send(0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c);
    wait_valid(0, 1'b0);
    take(0, "fips_r1");

    for (int i = 0; i < 3; i++) begin
      send(i, 128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 128'h8e4da1bc9fdc589d01010101c6c6c6c6);
      wait_valid(i, 1'b0);
      take(i, $sformatf("known_cols_i%0d", i));
    end

    send(0, 128'h00112233445566778899aabbccddeeff, 1'b1, 128'h00112233445566778899aabbccddeeff);
    wait_valid(0, 1'b0);
    take(0, "bypass_i0");
    send(2, 128'h00112233445566778899aabbccddeeff, 1'b1, 128'h00112233445566778899aabbccddeeff);
    wait_valid(2, 1'b0);
    take(2, "bypass_i2");

    // Backpressure, then same-edge accept of a second state
    a = rand128();
    b = rand128();
    send(0, a, 1'b0, model(a, 1'b0));
    wait_valid(0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'(i % 2);
      data_in[0]  = rand128();
      tick();
      check("bp_data",    data_out[0],            model(a, 1'b0));
      check("bp_inready", {127'b0, in_ready[0]},  128'd0);
      check("bp_valid",   {127'b0, out_valid[0]}, 128'd1);
    end
    data_in[0]   = b;
    bypass[0]    = 1'b0;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    #1;
    check("b2b_inready", {127'b0, in_ready[0]}, 128'd1);
    check("bp_result", data_out[0], exp_q[0].pop_front());
    tick();
    in_valid[0]   = 1'b0;
    out_ready[0]  = 1'b0;
    accept_cyc[0] = cyc;
    exp_q[0].push_back(model(b, 1'b0));
    check("b2b_busy_inready", {127'b0, in_ready[0]}, 128'd0);
    wait_valid(0, 1'b0);
    take(0, "b2b_result");

    // Reset after two column edges abandons the transaction
    c = rand128();
    send(0, c, 1'b0, model(c, 1'b0));
    tick();
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    void'(exp_q[0].pop_back());
    check("midrst_outvalid", {127'b0, out_valid[0]}, 128'd0);
    check("midrst_dataout",  data_out[0],            128'd0);
    check("midrst_inready",  {127'b0, in_ready[0]},  128'd1);
    for (int i = 0; i < 5; i++) tick();
    check("midrst_no_output", {127'b0, out_valid[0]}, 128'd0);
    d = rand128();
    send(0, d, 1'b0, model(d, 1'b0));
    wait_valid(0, 1'b0);
    take(0, "after_rst");

    // Inputs scrambled after the accept edge must not leak into the result
    for (int i = 0; i < 3; i++) begin
      a = rand128();
      send(i, a, 1'b0, model(a, 1'b0));
      wait_valid(i, 1'b1);
      take(i, $sformatf("scramble_i%0d", i));
      b = rand128();
      send(i, b, 1'b1, b);
      wait_valid(i, 1'b1);
      take(i, $sformatf("scramble_byp_i%0d", i));
    end

    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        logic byp;
        a   = rand128();
        byp = 1'($urandom_range(0, 3) == 0);
        send(i, a, byp, model(a, byp));
        wait_valid(i, 1'b0);
        take(i, $sformatf("rand_i%0d_%0d", i, j));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
